// File: rtl/array_read_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// array_read_sequencer_pkg
// Shared widths and the per-channel state encoding for the lookup-array
// read sequencer. The array has four ports, 256 entries and 8-bit data.
// No ports (package).
// ----------------------------------------------------------------------------
package array_read_sequencer_pkg;

  localparam int ARR_AW         = 8;
  localparam int ARR_DW         = 8;
  localparam int ARR_NPORT      = 4;
  localparam int ARR_FIFO_DEPTH = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } chanState_e;

endpackage : array_read_sequencer_pkg

// File: rtl/array_read_sequencer_channel.sv
// ----------------------------------------------------------------------------
// array_read_sequencer_channel
// One requester channel: accepts a 1-4 byte burst, walks the array address
// register across the burst, captures each returned byte into a small
// response FIFO and presents the FIFO head to the core.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_addr, req_len     burst start address and length-1
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_last    response byte and end-of-burst flag
//   arr_addr              registered address to the array port
//   arr_data              byte returned by the array for arr_addr
// ----------------------------------------------------------------------------
module array_read_sequencer_channel
  import array_read_sequencer_pkg::*;
#(
  parameter int AW         = ARR_AW,
  parameter int DW         = ARR_DW,
  parameter int FIFO_DEPTH = ARR_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic [AW-1:0] arr_addr,
  input  logic [DW-1:0] arr_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  chanState_e    state_q, state_d;
  logic [AW-1:0] arrAddr_q, arrAddr_d;
  logic [1:0]    remaining_q, remaining_d;
  logic [PW-1:0] rdPtr_q, wrPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic [DW:0]   fifoMem_q [FIFO_DEPTH];

  logic          push;
  logic          pop;
  logic          fifoFull;
  logic [DW:0]   headEntry;

  // Fullness is judged on the count at the start of the cycle, so a pop in
  // the same cycle never frees room for a push.
  assign fifoFull  = (count_q == CW'(FIFO_DEPTH));
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign headEntry = fifoMem_q[rdPtr_q];
  assign rsp_data  = rsp_valid ? headEntry[DW-1:0] : '0;
  assign rsp_last  = rsp_valid && headEntry[DW];
  assign arr_addr  = arrAddr_q;

  // Next-state logic: IDLE waits for a request, FETCH pushes one byte per
  // cycle while there is room and stalls (holding address) when full.
  always_comb begin
    state_d     = state_q;
    arrAddr_d   = arrAddr_q;
    remaining_d = remaining_q;
    req_ready   = 1'b0;
    push        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ready is withheld while reset is asserted.
        req_ready = reset;
        if (req_valid) begin
          arrAddr_d   = req_addr;
          remaining_d = req_len;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!fifoFull) begin
          push = 1'b1;
          if (remaining_q == 2'd0) begin
            state_d = ST_IDLE;
          end else begin
            arrAddr_d   = arrAddr_q + 1'b1;
            remaining_d = remaining_q - 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO occupancy bookkeeping; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State, address counter and FIFO storage. Reset drops any burst in flight
  // and empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      arrAddr_q   <= '0;
      remaining_q <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      arrAddr_q   <= arrAddr_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      if (push) begin
        fifoMem_q[wrPtr_q] <= {(remaining_q == 2'd0), arr_data};
        wrPtr_q            <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

endmodule : array_read_sequencer_channel

// File: rtl/array_read_sequencer.sv
// ----------------------------------------------------------------------------
// array_read_sequencer
// Four independent read channels in front of the 4-port lookup array. This
// level only slices the flat buses into per-channel fields.
// Ports (channel n occupies slice n of every bus):
//   clk, reset            clock, synchronous active-low reset
//   req_valid/req_ready   per-channel request handshake
//   req_addr, req_len     per-channel burst start address and length-1
//   rsp_valid/rsp_ready   per-channel response handshake
//   rsp_data, rsp_last    per-channel response byte and end-of-burst flag
//   arr_addr, arr_data    array AddressBusN / DataBusN
// ----------------------------------------------------------------------------
module array_read_sequencer
  import array_read_sequencer_pkg::*;
#(
  parameter int NPORT      = ARR_NPORT,
  parameter int AW         = ARR_AW,
  parameter int DW         = ARR_DW,
  parameter int FIFO_DEPTH = ARR_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    req_valid,
  output logic [NPORT-1:0]    req_ready,
  input  logic [NPORT*AW-1:0] req_addr,
  input  logic [NPORT*2-1:0]  req_len,
  output logic [NPORT-1:0]    rsp_valid,
  input  logic [NPORT-1:0]    rsp_ready,
  output logic [NPORT*DW-1:0] rsp_data,
  output logic [NPORT-1:0]    rsp_last,
  output logic [NPORT*AW-1:0] arr_addr,
  input  logic [NPORT*DW-1:0] arr_data
);

  for (genvar n = 0; n < NPORT; n++) begin : gen_chan
    array_read_sequencer_channel #(
      .AW         (AW),
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[n]),
      .req_ready (req_ready[n]),
      .req_addr  (req_addr[n*AW +: AW]),
      .req_len   (req_len[n*2 +: 2]),
      .rsp_valid (rsp_valid[n]),
      .rsp_ready (rsp_ready[n]),
      .rsp_data  (rsp_data[n*DW +: DW]),
      .rsp_last  (rsp_last[n]),
      .arr_addr  (arr_addr[n*AW +: AW]),
      .arr_data  (arr_data[n*DW +: DW])
    );
  end

endmodule : array_read_sequencer

// File: tb/tb_array_read_sequencer.sv
// ----------------------------------------------------------------------------
// tb_array_read_sequencer
// Self-checking bench for array_read_sequencer. An identity array model
// (Data[a]=a) answers every port; expected bytes are queued per channel when
// a request is driven and compared as the DUT hands responses to the core.
// ----------------------------------------------------------------------------
module tb_array_read_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_last;
  logic [31:0] arr_addr;
  logic [31:0] arr_data;

  int checks   = 0;
  int failures = 0;
  bit arrModelReady = 1'b0;

  // Expected {last, data} per channel, oldest first.
  logic [8:0] sbQ [4][$];

  always #5 clk = ~clk;

  array_read_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .arr_addr  (arr_addr),
    .arr_data  (arr_data)
  );

  // Identity lookup array, silent until its own reset is released.
  always_comb begin
    arr_data = '0;
    for (int p = 0; p < 4; p++) begin
      arr_data[p*8 +: 8] = arrModelReady ? arr_addr[p*8 +: 8] : 8'h00;
    end
  end

  // Response scoreboard: every handshake that the next rising edge will
  // complete is checked against the oldest expected byte of that channel.
  always @(negedge clk) begin : monitor
    logic [8:0] expEntry;
    if (reset === 1'b1) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (rsp_valid[ch] === 1'b1 && rsp_ready[ch] === 1'b1) begin
          checks++;
          if (sbQ[ch].size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_rsp ch%0d: got data=%02h last=%0b, required no response",
                     ch, rsp_data[ch*8 +: 8], rsp_last[ch]);
          end else begin
            expEntry = sbQ[ch].pop_front();
            if ({rsp_last[ch], rsp_data[ch*8 +: 8]} !== expEntry) begin
              failures++;
              $display("[TB] FAIL rsp_byte ch%0d: got data=%02h last=%0b, required data=%02h last=%0b",
                       ch, rsp_data[ch*8 +: 8], rsp_last[ch], expEntry[7:0], expEntry[8]);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void pushExpected(input int ch, input int addr, input int len);
    for (int i = 0; i <= len; i++) begin
      sbQ[ch].push_back({(i == len), 8'(addr + i)});
    end
  endfunction

  // Drives one request, queues its bytes and returns after the accepting
  // edge; waits is the number of cycles spent before ready, -1 on timeout.
  task automatic issueReq(input int ch, input int addr, input int len, output int waits);
    pushExpected(ch, addr, len);
    req_valid[ch]        = 1'b1;
    req_addr[ch*8 +: 8]  = 8'(addr);
    req_len[ch*2 +: 2]   = 2'(len);
    waits = 0;
    while (req_ready[ch] !== 1'b1 && waits < 50) begin
      tick();
      waits++;
    end
    if (req_ready[ch] !== 1'b1) waits = -1;
    tick();
    req_valid[ch] = 1'b0;
  endtask

  task automatic waitDrain(input int ch, input int budget, output bit drained);
    int n = 0;
    while (sbQ[ch].size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    drained = (sbQ[ch].size() == 0);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = '0;
    repeat (3) tick();
    arrModelReady = 1'b1;
    checks++;
    if (req_ready !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_req_ready: got %h, required 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 4'h0 || rsp_last !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_flags: got valid=%h last=%h, required 0/0", rsp_valid, rsp_last);
    end
    checks++;
    if (rsp_data !== 32'h0 || arr_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_buses: got rsp_data=%h arr_addr=%h, required 0/0", rsp_data, arr_addr);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (req_ready !== 4'hF) begin
      failures++;
      $display("[TB] FAIL post_reset_ready: got %h, required f", req_ready);
    end
  endtask

  task automatic test_single();
    bit drained;
    rsp_ready = 4'hF;
    pushExpected(0, 'h10, 0);
    req_valid[0]   = 1'b1;
    req_addr[7:0]  = 8'h10;
    req_len[1:0]   = 2'd0;
    checks++;
    if (req_ready[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_ready: got %b, required 1", req_ready[0]);
    end
    tick();
    req_valid[0] = 1'b0;
    checks++;
    if (rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_early_valid: got %b, required 0", rsp_valid[0]);
    end
    tick();
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_data[7:0] !== 8'h10 || rsp_last[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_latency: got valid=%b data=%02h last=%b, required 1/10/1",
               rsp_valid[0], rsp_data[7:0], rsp_last[0]);
    end
    waitDrain(0, 20, drained);
    checks++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL single_drain: got %0d bytes outstanding, required 0", sbQ[0].size());
    end
  endtask

  task automatic test_wrap();
    bit drained;
    int waits;
    issueReq(1, 'hFE, 3, waits);
    checks++;
    if (waits != 0) begin
      failures++;
      $display("[TB] FAIL wrap_accept: got waits=%0d, required 0", waits);
    end
    waitDrain(1, 30, drained);
    checks++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL wrap_drain: got %0d bytes outstanding, required 0", sbQ[1].size());
    end
  endtask

  task automatic test_backpressure();
    bit drained;
    int waits;
    rsp_ready[2] = 1'b0;
    issueReq(2, 'h40, 3, waits);
    repeat (5) tick();
    checks++;
    if (arr_addr[23:16] !== 8'h42 || req_ready[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_hold: got arr_addr=%02h req_ready=%b, required 42/0",
               arr_addr[23:16], req_ready[2]);
    end
    checks++;
    if (rsp_valid[2] !== 1'b1 || rsp_data[23:16] !== 8'h40 || rsp_last[2] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_head: got valid=%b data=%02h last=%b, required 1/40/0",
               rsp_valid[2], rsp_data[23:16], rsp_last[2]);
    end
    rsp_ready[2] = 1'b1;
    waitDrain(2, 30, drained);
    checks++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL stall_drain: got %0d bytes outstanding, required 0", sbQ[2].size());
    end
    repeat (2) tick();
    checks++;
    if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_idle: got valid=%b ready=%b, required 0/1", rsp_valid[2], req_ready[2]);
    end
  endtask

  task automatic test_all_channels();
    bit drained;
    pushExpected(0, 'h00, 1);
    pushExpected(1, 'h55, 1);
    pushExpected(2, 'hAA, 1);
    pushExpected(3, 'hFF, 1);
    rsp_ready = 4'hF;
    req_addr  = 32'hFFAA5500;
    req_len   = 8'b01010101;
    req_valid = 4'hF;
    checks++;
    if (req_ready !== 4'hF) begin
      failures++;
      $display("[TB] FAIL all_ready: got %h, required f", req_ready);
    end
    tick();
    req_valid = 4'h0;
    checks++;
    if (rsp_valid !== 4'h0) begin
      failures++;
      $display("[TB] FAIL all_early_valid: got %h, required 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'hF || rsp_data !== 32'hFFAA5500) begin
      failures++;
      $display("[TB] FAIL all_first_byte: got valid=%h data=%h, required f/ffaa5500", rsp_valid, rsp_data);
    end
    for (int ch = 0; ch < 4; ch++) begin
      waitDrain(ch, 20, drained);
      checks++;
      if (!drained) begin
        failures++;
        $display("[TB] FAIL all_drain ch%0d: got %0d bytes outstanding, required 0", ch, sbQ[ch].size());
      end
    end
  endtask

  task automatic test_reset_midburst();
    bit drained;
    int waits;
    rsp_ready[3] = 1'b0;
    issueReq(3, 'h80, 3, waits);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 4'h0 || arr_addr[31:24] !== 8'h00 || req_ready !== 4'h0) begin
      failures++;
      $display("[TB] FAIL midburst_reset: got valid=%h arr_addr=%02h ready=%h, required 0/00/0",
               rsp_valid, arr_addr[31:24], req_ready);
    end
    for (int ch = 0; ch < 4; ch++) sbQ[ch].delete();
    reset        = 1'b1;
    rsp_ready[3] = 1'b1;
    tick();
    issueReq(3, 'h05, 0, waits);
    waitDrain(3, 20, drained);
    checks++;
    if (!drained || arr_addr[31:24] !== 8'h05) begin
      failures++;
      $display("[TB] FAIL post_reset_req: got outstanding=%0d arr_addr=%02h, required 0/05",
               sbQ[3].size(), arr_addr[31:24]);
    end
  endtask

  task automatic test_back_to_back();
    bit drained;
    int waits = 0;
    rsp_ready[0] = 1'b1;
    pushExpected(0, 'h20, 1);
    pushExpected(0, 'h30, 0);
    req_valid[0]  = 1'b1;
    req_addr[7:0] = 8'h20;
    req_len[1:0]  = 2'd1;
    tick();
    req_addr[7:0] = 8'h30;
    req_len[1:0]  = 2'd0;
    while (req_ready[0] !== 1'b1 && waits < 20) begin
      tick();
      waits++;
    end
    checks++;
    if (waits != 2) begin
      failures++;
      $display("[TB] FAIL b2b_gap: got %0d cycles to ready, required 2", waits);
    end
    tick();
    req_valid[0] = 1'b0;
    waitDrain(0, 20, drained);
    checks++;
    if (!drained) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got %0d bytes outstanding, required 0", sbQ[0].size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_all_channels();
    test_reset_midburst();
    test_back_to_back();
    repeat (3) tick();
    for (int ch = 0; ch < 4; ch++) begin
      checks++;
      if (sbQ[ch].size() != 0) begin
        failures++;
        $display("[TB] FAIL leftover ch%0d: got %0d bytes outstanding, required 0", ch, sbQ[ch].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_array_read_sequencer
